// File: rtl/gate_deadtime.sv
// Three-phase gate-drive conditioning: complementary high/low gate commands with
// programmable dead time and a latched external fault that forces all gates off.
module gate_deadtime #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                pwmA_in,
    input  logic                pwmB_in,
    input  logic                pwmC_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                enable,
    input  logic                fault_in,
    input  logic                fault_clear,
    output logic                gate_AH,
    output logic                gate_AL,
    output logic                gate_BH,
    output logic                gate_BL,
    output logic                gate_CH,
    output logic                gate_CL,
    output logic                fault_latched
);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        LOW    = 3'd1,
        DEAD_H = 3'd2,
        HIGH   = 3'd3,
        DEAD_L = 3'd4
    } phase_state_e;

    localparam logic [DT_WIDTH-1:0] CNT_ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

    phase_state_e        state_q [3];
    phase_state_e        state_d [3];
    logic [DT_WIDTH-1:0] cnt_q   [3];
    logic [DT_WIDTH-1:0] cnt_d   [3];
    logic [2:0]          gateH_q, gateH_d;
    logic [2:0]          gateL_q, gateL_d;
    logic                fault_q, fault_d;
    logic                forceOff;
    logic [DT_WIDTH-1:0] deadLoad;
    logic [2:0]          pwm;

    assign pwm      = {pwmC_in, pwmB_in, pwmA_in};
    assign deadLoad = (dead_time == '0) ? CNT_ONE : dead_time;

    // A new fault wins over a simultaneous clear; the raw fault_in term lets the
    // gates drop on the very edge that latches the fault.
    assign fault_d  = fault_in | (fault_q & ~fault_clear);
    assign forceOff = ~enable | fault_q | fault_in;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            state_d[p] = state_q[p];
            cnt_d[p]   = cnt_q[p];
            if (forceOff) begin
                state_d[p] = OFF;
            end else begin
                case (state_q[p])
                    OFF: begin
                        state_d[p] = pwm[p] ? DEAD_H : DEAD_L;
                        cnt_d[p]   = deadLoad;
                    end
                    LOW: begin
                        if (pwm[p]) begin
                            state_d[p] = DEAD_H;
                            cnt_d[p]   = deadLoad;
                        end
                    end
                    HIGH: begin
                        if (!pwm[p]) begin
                            state_d[p] = DEAD_L;
                            cnt_d[p]   = deadLoad;
                        end
                    end
                    // A command reversal inside the dead band returns to the side that
                    // was already conducting, so short pulses are swallowed.
                    DEAD_H: begin
                        if (!pwm[p]) begin
                            state_d[p] = LOW;
                        end else if (cnt_q[p] <= CNT_ONE) begin
                            state_d[p] = HIGH;
                        end else begin
                            cnt_d[p] = cnt_q[p] - CNT_ONE;
                        end
                    end
                    DEAD_L: begin
                        if (pwm[p]) begin
                            state_d[p] = HIGH;
                        end else if (cnt_q[p] <= CNT_ONE) begin
                            state_d[p] = LOW;
                        end else begin
                            cnt_d[p] = cnt_q[p] - CNT_ONE;
                        end
                    end
                    default: state_d[p] = OFF;
                endcase
            end
            gateH_d[p] = (state_d[p] == HIGH);
            gateL_d[p] = (state_d[p] == LOW);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int p = 0; p < 3; p++) begin
                state_q[p] <= OFF;
                cnt_q[p]   <= '0;
            end
            gateH_q <= '0;
            gateL_q <= '0;
            fault_q <= 1'b0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                state_q[p] <= state_d[p];
                cnt_q[p]   <= cnt_d[p];
            end
            gateH_q <= gateH_d;
            gateL_q <= gateL_d;
            fault_q <= fault_d;
        end
    end

    assign gate_AH       = gateH_q[0];
    assign gate_AL       = gateL_q[0];
    assign gate_BH       = gateH_q[1];
    assign gate_BL       = gateL_q[1];
    assign gate_CH       = gateH_q[2];
    assign gate_CL       = gateL_q[2];
    assign fault_latched = fault_q;

endmodule

// File: tb/tb_gate_deadtime.sv
// Directed bench for gate_deadtime: dead-band timing, pulse swallowing, fault latch,
// in-flight dead-time changes, asynchronous reset and enable.
module tb_gate_deadtime;

    logic       clk;
    logic       rstb;
    logic [2:0] pwm;
    logic [7:0] deadTime;
    logic       enable;
    logic       faultIn;
    logic       faultClear;
    logic       gateAH, gateAL, gateBH, gateBL, gateCH, gateCL;
    logic       faultLatched;

    int nCompared   = 0;
    int nMismatched = 0;

    gate_deadtime #(.DT_WIDTH(8)) dut (
        .clk           (clk),
        .rstb          (rstb),
        .pwmA_in       (pwm[0]),
        .pwmB_in       (pwm[1]),
        .pwmC_in       (pwm[2]),
        .dead_time     (deadTime),
        .enable        (enable),
        .fault_in      (faultIn),
        .fault_clear   (faultClear),
        .gate_AH       (gateAH),
        .gate_AL       (gateAL),
        .gate_BH       (gateBH),
        .gate_BL       (gateBL),
        .gate_CH       (gateCH),
        .gate_CL       (gateCL),
        .fault_latched (faultLatched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle ordered {AH, AL, BH, BL, CH, CL, fault_latched}.
    function automatic logic [6:0] outs();
        return {gateAH, gateAL, gateBH, gateBL, gateCH, gateCL, faultLatched};
    endfunction

    function automatic logic [1:0] phaseGates(input int ph);
        case (ph)
            0:       return {gateAH, gateAL};
            1:       return {gateBH, gateBL};
            default: return {gateCH, gateCL};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkPhase(input string tag, input int ph, input logic [1:0] expected);
        checkOutput(tag, {5'b0, phaseGates(ph)}, {5'b0, expected});
    endtask

    task automatic applyStimulus(input logic [2:0] p, input logic en, input logic fIn, input logic fClr);
        pwm        = p;
        enable     = en;
        faultIn    = fIn;
        faultClear = fClr;
    endtask

    // Advance past one rising edge and check the shoot-through invariant there.
    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput("noShootThrough", {4'b0, gateAH & gateAL, gateBH & gateBL, gateCH & gateCL}, 7'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one phase edge, expect d cycles of both-off then conduction on edge k+d.
    task automatic runEdge(input int ph, input logic level, input int d, input string tag);
        pwm[ph] = level;
        for (int i = 0; i < d; i++) begin
            tick();
            checkPhase($sformatf("%s_dead%0d", tag, i), ph, 2'b00);
        end
        tick();
        checkPhase($sformatf("%s_conduct", tag), ph, level ? 2'b10 : 2'b01);
    endtask

    initial begin
        rstb     = 1'b0;
        deadTime = 8'd5;
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        #2;
        ticks(2);
        checkOutput("resetState", outs(), 7'b0000000);

        // Startup: every phase passes through a 5-cycle dead band into LOW.
        rstb = 1'b1;
        applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
        ticks(5);
        checkOutput("startupDead", outs(), 7'b0000000);
        tick();
        checkOutput("startupLow", outs(), 7'b0101010);

        // Phase A square wave, 40 high / 40 low, dead time 5.
        runEdge(0, 1'b1, 5, "aRise");
        ticks(34);
        checkPhase("aHighHold", 0, 2'b10);
        runEdge(0, 1'b0, 5, "aFall");
        ticks(34);
        checkPhase("aLowHold", 0, 2'b01);

        // Zero dead time still gives a one-cycle dead band.
        deadTime = 8'd0;
        runEdge(1, 1'b1, 1, "bRiseDt0");
        ticks(3);
        runEdge(1, 1'b0, 1, "bFallDt0");

        // Narrow 3-cycle pulse on C with dead time 8 is swallowed.
        deadTime = 8'd8;
        pwm[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkPhase($sformatf("cNarrow%0d", i), 2, 2'b00);
        end
        pwm[2] = 1'b0;
        tick();
        checkPhase("cNarrowBackLow", 2, 2'b01);

        // Fault while A conducts high and B sits in DEAD_L.
        deadTime = 8'd5;
        runEdge(0, 1'b1, 5, "aRisePreFault");
        runEdge(1, 1'b1, 5, "bRisePreFault");
        pwm[1] = 1'b0;
        tick();
        checkPhase("bDeadLPreFault", 1, 2'b00);
        tick();
        faultIn = 1'b1;
        tick();
        checkOutput("faultSameEdge", outs(), 7'b0000001);
        faultIn = 1'b0;
        ticks(3);
        checkOutput("faultHeld", outs(), 7'b0000001);
        applyStimulus(3'b001, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("faultWinsClear", outs(), 7'b0000001);
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("faultStillLatched", outs(), 7'b0000001);
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("faultCleared", outs(), 7'b0000000);
        faultClear = 1'b0;
        ticks(5);
        checkOutput("restartDead", outs(), 7'b0000000);
        tick();
        checkOutput("restartConduct", outs(), 7'b1001010);

        // Dead time 10 loaded at the interval start, changed to 2 mid-count.
        deadTime = 8'd10;
        pwm[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkPhase($sformatf("dtInFlight%0d", i), 0, 2'b00);
            if (i == 2) deadTime = 8'd2;
        end
        tick();
        checkPhase("dtInFlightEnd", 0, 2'b01);
        runEdge(0, 1'b1, 2, "dtNext");

        // Asynchronous reset while B is mid-DEAD_H (A high, C low).
        deadTime = 8'd5;
        pwm[1] = 1'b1;
        tick();
        checkPhase("bDeadHPreReset", 1, 2'b00);
        tick();
        rstb = 1'b0;
        #1;
        checkOutput("asyncReset", outs(), 7'b0000000);
        ticks(2);
        checkOutput("resetHeld", outs(), 7'b0000000);
        rstb = 1'b1;
        applyStimulus(3'b011, 1'b1, 1'b0, 1'b0);
        ticks(5);
        checkOutput("postResetDead", outs(), 7'b0000000);
        tick();
        checkOutput("postResetConduct", outs(), 7'b1010010);

        // Enable low zeroes gates on the sampling edge; re-enable restarts with dead band.
        enable = 1'b0;
        tick();
        checkOutput("enableOff", outs(), 7'b0000000);
        enable = 1'b1;
        ticks(5);
        checkOutput("reEnableDead", outs(), 7'b0000000);
        ticks(2);
        checkOutput("reEnableConduct", outs(), 7'b1010010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
